prng_stream_checker: RTL and testbench

PRNG_STREAM_CHECKER -- requirements
Module: prng_stream_checker

---
 rtl/prng_stream_checker_if.sv | 11 +
 rtl/prng_stream_checker.sv | 167 ++++++++++++++++
 tb/tb_prng_stream_checker.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/prng_stream_checker_if.sv
// AXI4-Stream style valid/ready/data bundle shared by the PRNG producer and checker.
interface AXI4S #(
  parameter int WIDTH = 4
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport Master (output valid, output data, input ready);
  modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/prng_stream_checker.sv
// PRNG stream checker: regenerates the producer's LFSR sequence and scores an
// AXI4-Stream of beats against it (counts, first error index, EXCLUDE sightings).
module prng_stream_checker #(
  parameter int                     SEED           = 45,
  parameter int                     OUTPUT_SIZE    = 4,
  parameter logic [OUTPUT_SIZE-1:0] EXCLUDE        = OUTPUT_SIZE'(8),
  parameter int                     LFSR_SIZE      = 8,
  parameter int                     EXPECTED_COUNT = 16,
  parameter logic [7:0]             READY_PATTERN  = 8'hFF,
  parameter int                     COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  AXI4S.Slave                    in,
  input  logic                   start,
  output logic [COUNT_WIDTH-1:0] receivedCount,
  output logic [COUNT_WIDTH-1:0] errorCount,
  output logic [COUNT_WIDTH-1:0] firstErrorIndex,
  output logic                   excludeSeen,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_SIZE-1:0]   SEED_STATE = (LFSR_SIZE'(SEED) == '0) ? LFSR_SIZE'(1) : LFSR_SIZE'(SEED);
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(EXPECTED_COUNT);

  function automatic logic [LFSR_SIZE-1:0] lfsr_step(input logic [LFSR_SIZE-1:0] s);
    return {s[LFSR_SIZE-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  state_t                 state_q, state_d;
  logic [LFSR_SIZE-1:0]   lfsr_q, lfsr_d;
  logic                   exp_valid_q, exp_valid_d;
  logic [2:0]             phase_q, phase_d;
  logic [COUNT_WIDTH-1:0] recv_q, recv_d;
  logic [COUNT_WIDTH-1:0] err_q, err_d;
  logic [COUNT_WIDTH-1:0] first_q, first_d;
  logic                   found_q, found_d;
  logic                   excl_q, excl_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;

  logic [LFSR_SIZE-1:0]   stepped_s;
  logic                   handshake_s;
  logic                   cur_ok_s;
  logic                   step_ok_s;

  assign stepped_s   = lfsr_step(lfsr_q);
  assign handshake_s = in.valid & ready_q;
  assign cur_ok_s    = (lfsr_q[OUTPUT_SIZE-1:0] != EXCLUDE);
  assign step_ok_s   = (stepped_s[OUTPUT_SIZE-1:0] != EXCLUDE);

  // Next-state, scoring and output decode.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    exp_valid_d = exp_valid_q;
    phase_d     = phase_q;
    recv_d      = recv_q;
    err_d       = err_q;
    first_d     = first_q;
    found_d     = found_q;
    excl_d      = excl_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = PRIME;
          lfsr_d      = SEED_STATE;
          exp_valid_d = 1'b0;
          phase_d     = 3'd0;
          recv_d      = '0;
          err_d       = '0;
          first_d     = '0;
          found_d     = 1'b0;
          excl_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      PRIME: begin
        if (cur_ok_s) begin
          exp_valid_d = 1'b1;
          state_d     = RUN;
        end else begin
          lfsr_d      = stepped_s;
          exp_valid_d = step_ok_s;
          state_d     = step_ok_s ? RUN : PRIME;
        end
      end
      RUN: begin
        phase_d = phase_q + 3'd1;
        if (handshake_s) begin
          recv_d      = recv_q + COUNT_WIDTH'(1);
          lfsr_d      = stepped_s;
          exp_valid_d = step_ok_s;
          if (in.data != lfsr_q[OUTPUT_SIZE-1:0]) begin
            err_d   = (err_q == '1) ? err_q : err_q + COUNT_WIDTH'(1);
            found_d = 1'b1;
            first_d = found_q ? first_q : recv_q;
          end else begin
            err_d = err_q;
          end
          excl_d  = excl_q | (in.data == EXCLUDE);
          state_d = (recv_d == LAST_COUNT) ? DONE : RUN;
        end else if (!exp_valid_q) begin
          if (cur_ok_s) begin
            exp_valid_d = 1'b1;
          end else begin
            lfsr_d      = stepped_s;
            exp_valid_d = step_ok_s;
          end
        end else begin
          lfsr_d = lfsr_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == RUN) & exp_valid_d & READY_PATTERN[phase_d];
    done_d  = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_STATE;
      exp_valid_q <= 1'b0;
      phase_q     <= 3'd0;
      recv_q      <= '0;
      err_q       <= '0;
      first_q     <= '0;
      found_q     <= 1'b0;
      excl_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      exp_valid_q <= exp_valid_d;
      phase_q     <= phase_d;
      recv_q      <= recv_d;
      err_q       <= err_d;
      first_q     <= first_d;
      found_q     <= found_d;
      excl_q      <= excl_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign in.ready        = ready_q;
  assign receivedCount   = recv_q;
  assign errorCount      = err_q;
  assign firstErrorIndex = first_q;
  assign excludeSeen     = excl_q;
  assign done            = done_q;

endmodule

// File: tb/tb_prng_stream_checker.sv
// Directed bench for prng_stream_checker: a cycle table on the default build plus
// short sequences on EXCLUDE=10, READY_PATTERN=0x55 and SEED=0 builds.
module tb_prng_stream_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  AXI4S #(.WIDTH(4)) ax_def ();
  AXI4S #(.WIDTH(4)) ax_exc ();
  AXI4S #(.WIDTH(4)) ax_rp ();
  AXI4S #(.WIDTH(4)) ax_s0 ();

  logic        start_def, start_exc, start_rp, start_s0;
  logic [15:0] recv_def, err_def, first_def;
  logic [15:0] recv_exc, err_exc, first_exc;
  logic [15:0] recv_rp, err_rp, first_rp;
  logic [15:0] recv_s0, err_s0, first_s0;
  logic        excl_def, excl_exc, excl_rp, excl_s0;
  logic        done_def, done_exc, done_rp, done_s0;

  prng_stream_checker u_def (
    .clk(clk), .reset(reset), .in(ax_def), .start(start_def),
    .receivedCount(recv_def), .errorCount(err_def), .firstErrorIndex(first_def),
    .excludeSeen(excl_def), .done(done_def)
  );

  prng_stream_checker #(.EXCLUDE(4'd10)) u_exc (
    .clk(clk), .reset(reset), .in(ax_exc), .start(start_exc),
    .receivedCount(recv_exc), .errorCount(err_exc), .firstErrorIndex(first_exc),
    .excludeSeen(excl_exc), .done(done_exc)
  );

  prng_stream_checker #(.READY_PATTERN(8'h55)) u_rp (
    .clk(clk), .reset(reset), .in(ax_rp), .start(start_rp),
    .receivedCount(recv_rp), .errorCount(err_rp), .firstErrorIndex(first_rp),
    .excludeSeen(excl_rp), .done(done_rp)
  );

  prng_stream_checker #(.SEED(0), .EXPECTED_COUNT(2)) u_s0 (
    .clk(clk), .reset(reset), .in(ax_s0), .start(start_s0),
    .receivedCount(recv_s0), .errorCount(err_s0), .firstErrorIndex(first_s0),
    .excludeSeen(excl_s0), .done(done_s0)
  );

  typedef struct {
    logic        start;
    logic        valid;
    logic [3:0]  data;
    logic        ready;
    logic [15:0] recv;
    logic [15:0] err;
    logic [15:0] first;
    logic        excl;
    logic        done;
  } vec_t;

  vec_t       vecs [24];
  logic [3:0] stream_def [16];
  int         checks = 0;
  int         errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  initial begin
    int  idx;
    logic hs;

    // Seed-45 sequence with the default EXCLUDE (8) skipped.
    stream_def = '{4'd13, 4'd10, 4'd4, 4'd9, 4'd2, 4'd4, 4'd1, 4'd2,
                   4'd5, 4'd10, 4'd4, 4'd9, 4'd2, 4'd5, 4'd10, 4'd5};

    //          start valid data   ready recv    err     first   excl  done
    vecs[0]  = '{1'b1, 1'b0, 4'd0,  1'b0, 16'd0,  16'd0,  16'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd13, 1'b1, 16'd0,  16'd0,  16'd0,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd13, 1'b1, 16'd1,  16'd0,  16'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'd11, 1'b1, 16'd2,  16'd1,  16'd1,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd4,  1'b1, 16'd3,  16'd1,  16'd1,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd4,  1'b1, 16'd3,  16'd1,  16'd1,  1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'd9,  1'b1, 16'd4,  16'd1,  16'd1,  1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd2,  1'b1, 16'd5,  16'd1,  16'd1,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd8,  1'b0, 16'd6,  16'd2,  16'd1,  1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd1,  1'b1, 16'd6,  16'd2,  16'd1,  1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'd1,  1'b1, 16'd7,  16'd2,  16'd1,  1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'd2,  1'b1, 16'd8,  16'd2,  16'd1,  1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'd5,  1'b1, 16'd9,  16'd2,  16'd1,  1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'd10, 1'b1, 16'd10, 16'd2,  16'd1,  1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'd4,  1'b1, 16'd11, 16'd2,  16'd1,  1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 4'd9,  1'b1, 16'd12, 16'd2,  16'd1,  1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 4'd2,  1'b1, 16'd13, 16'd2,  16'd1,  1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'd5,  1'b1, 16'd14, 16'd2,  16'd1,  1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 4'd10, 1'b1, 16'd15, 16'd2,  16'd1,  1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'd5,  1'b0, 16'd16, 16'd2,  16'd1,  1'b1, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 4'd13, 1'b0, 16'd16, 16'd2,  16'd1,  1'b1, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 4'd0,  1'b0, 16'd0,  16'd0,  16'd0,  1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 4'd0,  1'b1, 16'd0,  16'd0,  16'd0,  1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 4'd13, 1'b1, 16'd1,  16'd0,  16'd0,  1'b0, 1'b0};

    reset = 1'b1;
    start_def = 1'b0; start_exc = 1'b0; start_rp = 1'b0; start_s0 = 1'b0;
    ax_def.valid = 1'b0; ax_def.data = 4'd0;
    ax_exc.valid = 1'b0; ax_exc.data = 4'd0;
    ax_rp.valid  = 1'b0; ax_rp.data  = 4'd0;
    ax_s0.valid  = 1'b0; ax_s0.data  = 4'd0;
    tick();
    tick();
    chk("rst_ready", int'(ax_def.ready), 0);
    chk("rst_recv",  int'(recv_def), 0);
    chk("rst_err",   int'(err_def), 0);
    chk("rst_first", int'(first_def), 0);
    chk("rst_excl",  int'(excl_def), 0);
    chk("rst_done",  int'(done_def), 0);
    reset = 1'b0;
    tick();
    chk("idle_ready", int'(ax_def.ready), 0);

    for (int i = 0; i < 24; i++) begin
      start_def    = vecs[i].start;
      ax_def.valid = vecs[i].valid;
      ax_def.data  = vecs[i].data;
      tick();
      chk($sformatf("v%0d_ready", i), int'(ax_def.ready), int'(vecs[i].ready));
      chk($sformatf("v%0d_recv", i),  int'(recv_def),     int'(vecs[i].recv));
      chk($sformatf("v%0d_err", i),   int'(err_def),      int'(vecs[i].err));
      chk($sformatf("v%0d_first", i), int'(first_def),    int'(vecs[i].first));
      chk($sformatf("v%0d_excl", i),  int'(excl_def),     int'(vecs[i].excl));
      chk($sformatf("v%0d_done", i),  int'(done_def),     int'(vecs[i].done));
    end
    start_def = 1'b0;

    // Mid-run reset wins over start and leaves nothing behind.
    for (int i = 1; i < 5; i++) begin
      ax_def.valid = 1'b1;
      ax_def.data  = stream_def[i];
      tick();
    end
    chk("pre_rst_recv", int'(recv_def), 5);
    reset = 1'b1; start_def = 1'b1;
    tick();
    chk("mid_rst_recv",  int'(recv_def), 0);
    chk("mid_rst_ready", int'(ax_def.ready), 0);
    chk("mid_rst_done",  int'(done_def), 0);
    reset = 1'b0; start_def = 1'b0;
    tick();
    tick();
    chk("rst_over_start_ready", int'(ax_def.ready), 0);
    start_def = 1'b1;
    tick();
    start_def = 1'b0;
    tick();
    chk("restart_ready", int'(ax_def.ready), 1);
    ax_def.data = 4'd13;
    tick();
    chk("restart_recv", int'(recv_def), 1);
    chk("restart_err",  int'(err_def), 0);
    ax_def.valid = 1'b0;

    // EXCLUDE=10: one skip cycle after beat 13, then 4 matches.
    start_exc = 1'b1;
    tick();
    chk("exc_prime_ready", int'(ax_exc.ready), 0);
    start_exc = 1'b0; ax_exc.valid = 1'b1; ax_exc.data = 4'd13;
    tick();
    chk("exc_first_ready", int'(ax_exc.ready), 1);
    tick();
    chk("exc_b0_recv",  int'(recv_exc), 1);
    chk("exc_b0_ready", int'(ax_exc.ready), 0);
    ax_exc.data = 4'd4;
    tick();
    chk("exc_skip_recv",  int'(recv_exc), 1);
    chk("exc_skip_ready", int'(ax_exc.ready), 1);
    tick();
    chk("exc_b1_recv", int'(recv_exc), 2);
    chk("exc_b1_err",  int'(err_exc), 0);
    ax_exc.valid = 1'b0;

    // READY_PATTERN=0x55: ready only on even phases, full run completes.
    start_rp = 1'b1;
    tick();
    chk("rp_prime_ready", int'(ax_rp.ready), 0);
    start_rp = 1'b0;
    tick();
    idx = 0;
    for (int t = 0; t < 31; t++) begin
      chk($sformatf("rp_ready_t%0d", t), int'(ax_rp.ready), (t % 2 == 0) ? 1 : 0);
      ax_rp.valid = 1'b1;
      ax_rp.data  = (idx < 16) ? stream_def[idx] : 4'd0;
      hs = ax_rp.ready;
      tick();
      if (hs) idx++;
    end
    chk("rp_beats", idx, 16);
    chk("rp_done",  int'(done_rp), 1);
    chk("rp_recv",  int'(recv_rp), 16);
    chk("rp_err",   int'(err_rp), 0);
    chk("rp_ready_done", int'(ax_rp.ready), 0);
    ax_rp.valid = 1'b0;

    // SEED=0 loads 1: sequence 1,2; two-beat run ends in DONE.
    start_s0 = 1'b1;
    tick();
    start_s0 = 1'b0; ax_s0.valid = 1'b1; ax_s0.data = 4'd1;
    tick();
    chk("s0_ready", int'(ax_s0.ready), 1);
    tick();
    chk("s0_b0_recv", int'(recv_s0), 1);
    ax_s0.data = 4'd2;
    tick();
    chk("s0_recv",  int'(recv_s0), 2);
    chk("s0_err",   int'(err_s0), 0);
    chk("s0_done",  int'(done_s0), 1);
    chk("s0_ready_done", int'(ax_s0.ready), 0);
    ax_s0.valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
